// File: rtl/weight_sram_bank.sv
// weight_sram_bank
//   Storage-side responder for the synapse weight-fetch interface. It holds
//   the flattened N*N signed weight matrix as DEPTH rows of LANES weights.
//   Each lane is its own WIDTH x DEPTH array, so one weight can be written
//   without a read-modify-write of the whole row.
//
//   Ports
//     clk, reset        clock; asynchronous active-high reset
//     rd_req_*          row read request (valid/ready, row address)
//     rd_rsp_*          row read response (valid/ready, LANES*WIDTH data);
//                       lane k holds weight index addr*LANES+k
//     wr_*              single-weight write (valid/ready, flat index, data)
//     init_done         bank is usable
//
//   Optional build macro WSRAM_CLEAR_ON_RESET_EN: after reset, sweep every
//   row to zero (one row per cycle) before raising init_done. Without it,
//   init_done rises on the first clock after reset and contents stay
//   undefined until written.
module weight_sram_bank #(
  parameter  int N     = 256,
  parameter  int WIDTH = 32,
  parameter  int LANES = 8,
  localparam int DEPTH = (N*N + LANES - 1) / LANES,
  localparam int AW    = $clog2(DEPTH),
  localparam int WAW   = $clog2(N*N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_req_valid,
  output logic                   rd_req_ready,
  input  logic [AW-1:0]          rd_req_addr,
  output logic                   rd_rsp_valid,
  input  logic                   rd_rsp_ready,
  output logic [LANES*WIDTH-1:0] rd_rsp_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [WAW-1:0]         wr_index,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   init_done
);

  localparam int LAW = (LANES > 1) ? $clog2(LANES) : 1;

  logic           rd_rsp_valid_q, rd_rsp_valid_d;
  logic           rd_fire, wr_fire, wr_in_range;
  logic [AW-1:0]  wr_row;
  logic [LAW-1:0] wr_lane;
  logic           clr_en;
  logic [AW-1:0]  clr_row;

  // Writes win arbitration; a read also waits until the response slot is
  // free or being drained this cycle.
  assign wr_ready     = init_done;
  assign rd_req_ready = init_done && !wr_valid && (!rd_rsp_valid_q || rd_rsp_ready);
  assign rd_fire      = rd_req_valid && rd_req_ready;
  assign wr_fire      = wr_valid && wr_ready;

  assign wr_in_range  = 32'(wr_index) < N*N;
  assign wr_row       = AW'(32'(wr_index) / LANES);
  assign wr_lane      = LAW'(32'(wr_index) % LANES);

  always_comb begin
    rd_rsp_valid_d = rd_rsp_valid_q;
    if (rd_fire)           rd_rsp_valid_d = 1'b1;
    else if (rd_rsp_ready) rd_rsp_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_rsp_valid_q <= 1'b0;
    else       rd_rsp_valid_q <= rd_rsp_valid_d;
  end

  assign rd_rsp_valid = rd_rsp_valid_q;

`ifdef WSRAM_CLEAR_ON_RESET_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_row_q, clr_row_d;

  always_comb begin
    state_d   = state_q;
    clr_row_d = clr_row_q;
    if (state_q == ST_CLEAR) begin
      if (clr_row_q == AW'(DEPTH - 1)) state_d   = ST_RUN;
      else                             clr_row_d = clr_row_q + AW'(1);
    end
  end

  // Any reset, including one mid-sweep, restarts the sweep at row 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_row_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_row_q <= clr_row_d;
    end
  end

  assign clr_en    = (state_q == ST_CLEAR);
  assign clr_row   = clr_row_q;
  assign init_done = (state_q == ST_RUN);
`else
  logic init_done_q, init_done_d;

  assign init_done_d = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) init_done_q <= 1'b0;
    else       init_done_q <= init_done_d;
  end

  assign clr_en    = 1'b0;
  assign clr_row   = '0;
  assign init_done = init_done_q;
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] data_q, data_d;
    logic             lane_live;

    // Covers both rows past DEPTH and the padding lanes of the last row:
    // anything whose flat index is beyond the matrix reads as zero.
    assign lane_live = (32'(rd_req_addr) * LANES + k) < N*N;

    always_ff @(posedge clk) begin
      if (clr_en)
        mem[clr_row] <= '0;
      else if (wr_fire && wr_in_range && wr_lane == LAW'(k))
        mem[wr_row] <= wr_data;
    end

    // Response register only loads on acceptance, so it holds under
    // backpressure.
    always_comb begin
      data_d = data_q;
      if (rd_fire) data_d = lane_live ? mem[rd_req_addr] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) data_q <= '0;
      else       data_q <= data_d;
    end

    assign rd_rsp_data[k*WIDTH +: WIDTH] = data_q;
  end

endmodule

// File: doc/weight_sram_bank.md
Name: weight_sram_bank

Overview:
- Storage-side responder for the synapse weight-fetch interface.
- Holds the flattened N×N signed weight matrix as rows of LANES weights.
- Serves row reads to the synapse datapath over a valid/ready request/response pair.
- Accepts single-weight writes from the host weight loader on a separate valid/ready port, arbitrated against reads.

Parameters:
- N, 256, neuron count; the matrix holds N*N weights.
- WIDTH, 32, bits per signed fixed-point weight.
- LANES, 8, weights per row; one read returns one row.
- DEPTH, (N*N+LANES-1)/LANES, number of rows (derived; do not override).
- AW, $clog2(DEPTH), row address width (derived).
- WAW, $clog2(N*N), weight index width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  read request accepted when high together with valid.
- rd_req_addr  in  AW  row address.
- rd_rsp_valid  out  1  response data valid.
- rd_rsp_ready  in  1  consumer takes the response.
- rd_rsp_data  out  LANES*WIDTH  row data; lane k at bits [k*WIDTH +: WIDTH] holds weight index addr*LANES+k.
- wr_valid  in  1  write valid.
- wr_ready  out  1  write accepted when high together with valid.
- wr_index  in  WAW  flat weight index i*N+j.
- wr_data  in  WIDTH  signed weight.
- init_done  out  1  bank is usable.

Behaviour:
- Reset values: rd_rsp_valid=0, rd_rsp_data=0, rd_req_ready=0, wr_ready=0. The storage array itself is not reset.
- init_done after reset: 1 in the first cycle after reset deasserts without the optional feature; see Optional Feature otherwise.
- Storage: LANES independent WIDTH-wide arrays of DEPTH entries, so a single lane can be written without read-modify-write.
- A write to wr_index targets row wr_index/LANES, lane wr_index%LANES.
- Arbitration: writes have priority.
  - wr_ready = init_done.
  - rd_req_ready = init_done && !wr_valid && (!rd_rsp_valid || rd_rsp_ready).
  - A read and a write are never accepted in the same cycle.
- Read latency: a request accepted at edge t presents rd_rsp_valid=1 and data after edge t (one cycle), from a synchronous array read.
- Back-to-back throughput: 1 row per cycle when rd_rsp_ready stays high.
- Backpressure: while rd_rsp_valid && !rd_rsp_ready, rd_rsp_data and rd_rsp_valid hold stable and no new read is accepted.
- rd_rsp_valid clears on handshake unless a new request is accepted in the same cycle.
- Ordering: a write accepted at edge t is visible to any read accepted at edge t+1 or later (no stale data).
- Boundaries:
  - Read with rd_req_addr >= DEPTH: accepted, returns all-zero row.
  - Write with wr_index >= N*N: accepted and dropped.
  - Padding lanes (row*LANES+k >= N*N) always read as zero, regardless of array contents.
- Reset mid-operation: an in-flight response is discarded and rd_rsp_valid drops immediately (asynchronous); array contents are retained.

Optional Feature:
- Macro: WSRAM_CLEAR_ON_RESET_EN.
- With the macro defined:
  - After reset deasserts, a two-state FSM (CLEAR, RUN) enters CLEAR.
  - In CLEAR, a row counter writes zero to all lanes of rows 0..DEPTH-1, one row per cycle; init_done=0 and both readies are 0 throughout.
  - After the last row is written, the FSM moves to RUN and init_done=1, exactly DEPTH cycles after reset deassertion.
  - Reset during CLEAR restarts the sweep at row 0.
- Without the macro: no FSM and no counter; init_done=1 from the first post-reset cycle; contents are undefined until written.

Test Plan:
- Write round trip: write indices 0..7 with values 1..8, then read row 0 → rd_rsp_data lanes 0..7 = 1..8, valid one cycle after acceptance.
- Negative weights: write index 65535 = -5 (0xFFFFFFFB), read row 8191 → lane 7 = 0xFFFFFFFB.
- Backpressure: hold rd_rsp_ready=0 for 4 cycles with rd_req_valid held high → data stable, rd_req_ready=0; release → 2 responses in 2 consecutive cycles.
- Collision: rd_req_valid and wr_valid high together for index 16 = 0x7 → write accepted first; the read of row 2 accepted next cycle returns lane 0 = 0x7.
- Out of range (N=250): write index 62500 dropped; read of row 7812 → lanes 4..7 = 0; read of row 9000 → all zero.
- With WSRAM_CLEAR_ON_RESET_EN: pulse reset → init_done low for exactly 8192 cycles; then any read → 0. Reset asserted at sweep cycle 100 → init_done rises 8192 cycles after the second reset release.
